// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED chase control plane.
// Also holds the pattern-cycling helper.
package led_ctrl_pkg;

  localparam int unsigned DEF_CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    WAIT_REL = 2'd2
  } btn_state_e;

  localparam logic [1:0] SPD_1S    = 2'd0;
  localparam logic [1:0] SPD_500MS = 2'd1;
  localparam logic [1:0] SPD_250MS = 2'd2;
  localparam logic [1:0] SPD_100MS = 2'd3;

  localparam logic [1:0] PAT_BOUNCE = 2'd0;
  localparam logic [1:0] PAT_WRAP   = 2'd1;
  localparam logic [1:0] PAT_FILL   = 2'd2;

  // Pattern sequence bounce -> wrap -> fill -> bounce; code 3 is never produced.
  function automatic logic [1:0] next_pattern(input logic [1:0] pat);
    logic [1:0] nxt;
    case (pat)
      PAT_BOUNCE: nxt = PAT_WRAP;
      PAT_WRAP:   nxt = PAT_FILL;
      default:    nxt = PAT_BOUNCE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_tick_divider.sv
// Programmable period divider producing a registered 1-cycle tick.
// Count is held while disabled; clear restarts the period and drops a pending tick.
module led_tick_divider
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             enable,
  input  logic             clear,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  // Divider count and registered tick strobe
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      if (count == period - CNT_W'(1)) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_chase_scheduler.sv
// Button-driven control for the LED chase: run/pause, speed and pattern selection,
// plus the step tick for the chase shifter.
module led_chase_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_0   = 10_000_000,
  parameter int unsigned PERIOD_1   = 5_000_000,
  parameter int unsigned PERIOD_2   = 2_500_000,
  parameter int unsigned PERIOD_3   = 1_000_000,
  parameter int unsigned LONG_PRESS = 15_000_000,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_valid,
  input  logic       btn_level,
  output logic       step_tick,
  output logic [1:0] speed_mode,
  output logic [1:0] pattern_sel,
  output logic       running
);

  localparam logic [CNT_W-1:0] P0        = CNT_W'(PERIOD_0);
  localparam logic [CNT_W-1:0] P1        = CNT_W'(PERIOD_1);
  localparam logic [CNT_W-1:0] P2        = CNT_W'(PERIOD_2);
  localparam logic [CNT_W-1:0] P3        = CNT_W'(PERIOD_3);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);

  btn_state_e       state;
  logic [CNT_W-1:0] hold;
  logic [CNT_W-1:0] period;
  logic             short_evt;
  logic             long_evt;
  logic             run_next;
  logic             div_clear;

  // Press classification; the divider sees the post-toggle run state so a pause blocks a same-cycle tick
  always_comb begin
    short_evt = (state == PRESS) && !btn_level;
    long_evt  = (state == PRESS) && btn_level && (hold == LONG_LAST);
    run_next  = long_evt ? ~running : running;
    div_clear = short_evt && running;
    case (speed_mode)
      SPD_1S:    period = P0;
      SPD_500MS: period = P1;
      SPD_250MS: period = P2;
      SPD_100MS: period = P3;
      default:   period = P0;
    endcase
  end

  // Button FSM, hold counter and mode/pattern registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      running     <= 1'b1;
      speed_mode  <= SPD_1S;
      pattern_sel <= PAT_BOUNCE;
    end else begin
      case (state)
        IDLE: begin
          if (btn_valid) begin
            state <= PRESS;
            hold  <= '0;
          end
        end
        PRESS: begin
          if (short_evt) begin
            state <= IDLE;
            if (running) speed_mode <= speed_mode + 2'd1;
            else         pattern_sel <= next_pattern(pattern_sel);
          end else if (long_evt) begin
            running <= ~running;
            state   <= WAIT_REL;
          end else begin
            hold <= hold + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (!btn_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  led_tick_divider #(
    .CNT_W(CNT_W)
  ) u_divider (
    .clk   (clk),
    .rst   (rst),
    .period(period),
    .enable(run_next),
    .clear (div_clear),
    .tick  (step_tick)
  );

endmodule

// File: tb/tb_led_chase_scheduler.sv
// Directed bench for led_chase_scheduler with short periods (8,6,4,2) and LONG_PRESS=20.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_led_chase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_valid = 1'b0;
  logic       btn_level = 1'b0;
  logic       step_tick;
  logic [1:0] speed_mode;
  logic [1:0] pattern_sel;
  logic       running;

  int total = 0;
  int bad   = 0;

  led_chase_scheduler #(
    .PERIOD_0  (8),
    .PERIOD_1  (6),
    .PERIOD_2  (4),
    .PERIOD_3  (2),
    .LONG_PRESS(20),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_valid  (btn_valid),
    .btn_level  (btn_level),
    .step_tick  (step_tick),
    .speed_mode (speed_mode),
    .pattern_sel(pattern_sel),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps n edges; a tick is expected at edge 'first' and every 'period' after (first=0: none).
  task automatic expect_ticks(input string tag, input int n, input int first, input int period);
    logic exp;
    for (int k = 1; k <= n; k++) begin
      cyc();
      exp = (first != 0) && (k >= first) && (((k - first) % period) == 0);
      chk(tag, {7'd0, step_tick}, {7'd0, exp});
    end
  endtask

  // Press edge, 'held' more edges at level lvl, then the release edge (action visible on return).
  task automatic press(input logic lvl, input int held);
    btn_valid = 1'b1;
    btn_level = lvl;
    cyc();
    btn_valid = 1'b0;
    repeat (held) cyc();
    btn_level = 1'b0;
    cyc();
  endtask

  initial begin
    // 1: reset state and free-running ticks at speed 0
    cyc();
    cyc();
    chk("rst_tick", {7'd0, step_tick}, 8'd0);
    chk("rst_speed", {6'd0, speed_mode}, 8'd0);
    chk("rst_pattern", {6'd0, pattern_sel}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd1);
    rst = 1'b0;
    expect_ticks("t1_tick", 24, 8, 8);
    chk("t1_speed", {6'd0, speed_mode}, 8'd0);
    chk("t1_running", {7'd0, running}, 8'd1);

    // 2: short press of 3 held cycles -> speed 1, tick 6 cycles after the clear
    press(1'b1, 2);
    chk("t2_speed", {6'd0, speed_mode}, 8'd1);
    chk("t2_tick_clr", {7'd0, step_tick}, 8'd0);
    expect_ticks("t2_tick", 6, 6, 6);

    // 3: four short presses cycle speed 2,3,0,1 with matching spacing
    press(1'b1, 0);
    chk("t3_speed2", {6'd0, speed_mode}, 8'd2);
    expect_ticks("t3_tick4", 8, 4, 4);
    press(1'b1, 0);
    chk("t3_speed3", {6'd0, speed_mode}, 8'd3);
    expect_ticks("t3_tick2", 4, 2, 2);
    press(1'b1, 0);
    chk("t3_speed0", {6'd0, speed_mode}, 8'd0);
    chk("t3_drop", {7'd0, step_tick}, 8'd0);
    expect_ticks("t3_tick8", 16, 8, 8);
    press(1'b1, 0);
    chk("t3_speed1", {6'd0, speed_mode}, 8'd1);
    expect_ticks("t3_tick6", 12, 6, 6);

    // 4: offset count to 3 so a tick falls due exactly on the pausing edge
    expect_ticks("t4_pre", 3, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      btn_valid = (k == 1) || (k == 10);
      btn_level = (k <= 25);
      cyc();
      chk("t4_pause_run", {7'd0, running}, {7'd0, (k < 21)});
      chk("t4_pause_tick", {7'd0, step_tick}, {7'd0, ((k < 21) && (((3 + k) % 6) == 0))});
    end
    for (int k = 1; k <= 27; k++) begin
      btn_valid = (k == 1);
      btn_level = (k <= 25);
      cyc();
      chk("t4_resume_run", {7'd0, running}, {7'd0, (k >= 21)});
      chk("t4_resume_tick", {7'd0, step_tick}, {7'd0, ((k == 21) || (k == 27))});
    end
    chk("t4_speed", {6'd0, speed_mode}, 8'd1);

    // 5: pause again, then cycle the pattern with short presses (last one a glitch press)
    for (int k = 1; k <= 22; k++) begin
      btn_valid = (k == 1);
      btn_level = (k <= 21);
      cyc();
      chk("t5_pause_run", {7'd0, running}, {7'd0, (k < 21)});
      chk("t5_pause_tick", {7'd0, step_tick}, {7'd0, ((k < 21) && ((k % 6) == 0))});
    end
    press(1'b1, 0);
    chk("t5_pat1", {6'd0, pattern_sel}, 8'd1);
    chk("t5_speed_a", {6'd0, speed_mode}, 8'd1);
    press(1'b1, 2);
    chk("t5_pat2", {6'd0, pattern_sel}, 8'd2);
    press(1'b0, 0);
    chk("t5_pat0_glitch", {6'd0, pattern_sel}, 8'd0);
    chk("t5_speed_b", {6'd0, speed_mode}, 8'd1);
    chk("t5_running", {7'd0, running}, 8'd0);
    expect_ticks("t5_no_tick", 10, 0, 0);

    // 6: reset asserted with hold=10; the release afterwards must not act
    btn_valid = 1'b1;
    btn_level = 1'b1;
    cyc();
    btn_valid = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    chk("t6_tick", {7'd0, step_tick}, 8'd0);
    chk("t6_speed", {6'd0, speed_mode}, 8'd0);
    chk("t6_pattern", {6'd0, pattern_sel}, 8'd0);
    chk("t6_running", {7'd0, running}, 8'd1);
    rst = 1'b0;
    cyc();
    chk("t6_tick_e1", {7'd0, step_tick}, 8'd0);
    btn_level = 1'b0;
    expect_ticks("t6_tick", 15, 7, 8);
    chk("t6_speed_after", {6'd0, speed_mode}, 8'd0);
    chk("t6_running_after", {7'd0, running}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
